// File: rtl/globals.sv
// Project-wide constants and shared types for the Hough pipeline.
package globals;

    // Frame size in pixels; scaled down for block-level simulation.
    localparam int IMAGE_SIZE = 16;
    localparam int ADDR_WIDTH = $clog2(IMAGE_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry register FIFO that absorbs the one-cycle BRAM read latency under backpressure.
module skid_buffer2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] tail;
    logic             do_pop;

    assign do_pop = pop && (occ != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word lands behind whatever remains.
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && occ == 2'd2));

endmodule

// File: rtl/bram_reader.sv
// Streams one image frame out of the BRAM into a downstream FIFO with wr_en/full flow control.
module bram_reader
    import globals::*;
#(
    parameter int BRAM_DATA_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      bram_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_rd_data,
    output logic                       out_wr_en,
    output logic [BRAM_DATA_WIDTH-1:0] out_din,
    input  logic                       out_full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_SIZE - 1);

    reader_state_t         state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  inflight;
    logic                  issue;
    logic                  pop;
    logic [1:0]            occ;
    logic [2:0]            pending;

    assign pop       = (occ != 2'd0) && !out_full;
    assign out_wr_en = pop;
    assign bram_rd_addr = addr;

    // Issue only if the word would still fit after this cycle's pop: occ + inflight - pop < 2.
    assign pending = {1'b0, occ} + {2'b00, inflight};
    assign issue   = (state == READ) && (pending < (3'd2 + {2'b00, pop}));

    assign busy = (state != IDLE);
    assign done = (state == DRAIN) && (occ == 2'd0) && !inflight;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        addr  <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (addr == LAST_ADDR) state <= DRAIN;
                        else                   addr  <= addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    skid_buffer2 #(
        .WIDTH(BRAM_DATA_WIDTH)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .push     (inflight),
        .push_data(bram_rd_data),
        .pop      (pop),
        .head     (out_din),
        .occ      (occ)
    );

endmodule

// File: tb/tb_bram_reader.sv
// Directed bench for bram_reader: unstalled, stalled, toggled, restart, reset and back-to-back frames.
module tb_bram_reader;
    import globals::*;

    localparam int W = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] bram_rd_addr;
    logic [W-1:0]          bram_rd_data;
    logic                  out_wr_en;
    logic [W-1:0]          out_din;
    logic                  out_full;

    logic [W-1:0] mem [IMAGE_SIZE];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    // Registered-read BRAM model.
    always @(posedge clock) bram_rd_data <= mem[bram_rd_addr];

    bram_reader #(
        .BRAM_DATA_WIDTH(W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data),
        .out_wr_en   (out_wr_en),
        .out_din     (out_din),
        .out_full    (out_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge; cycle 0 is the current cycle.
    // mode 0 plain, 1 full in 5..12, 2 full on odd cycles, 3 extra starts at 4/10/19, 4 reset at 8.
    task automatic run_frame(input int mode, input int exp_words, input int exp_first, input int exp_done_cyc);
        int nwords;
        int ndone;
        int done_cyc;
        int first_cyc;
        nwords = 0; ndone = 0; done_cyc = -1; first_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            start    = (c == 0) || (mode == 3 && (c == 4 || c == 10 || c == 19));
            out_full = (mode == 1 && c >= 5 && c <= 12) || (mode == 2 && (c % 2 == 1));
            reset    = (mode == 4 && c == 8);
            #4;
            if (c == 0) chk($sformatf("m%0d busy_at_start", mode), 32'(busy), 32'd0);
            if (out_wr_en) begin
                if (first_cyc < 0) first_cyc = c;
                chk($sformatf("m%0d word%0d", mode, nwords), 32'(out_din), 32'(nwords % 256));
                nwords++;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (mode == 4 && c == 9) begin
                chk("m4 busy_after_reset", 32'(busy), 32'd0);
                chk("m4 wr_en_after_reset", 32'(out_wr_en), 32'd0);
            end
            @(posedge clock);
            #1;
            if (ndone > 0) break;
        end
        reset = 1'b0;
        chk($sformatf("m%0d word_count", mode), 32'(nwords), 32'(exp_words));
        chk($sformatf("m%0d first_cycle", mode), 32'(first_cyc), 32'(exp_first));
        chk($sformatf("m%0d done_count", mode), 32'(ndone), (exp_done_cyc < 0) ? 32'd0 : 32'd1);
        chk($sformatf("m%0d done_cycle", mode), 32'(done_cyc), 32'(exp_done_cyc));
    endtask

    task automatic idle_check(input string tag);
        start    = 1'b0;
        out_full = 1'b0;
        reset    = 1'b0;
        #4;
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
        chk({tag, " done_idle"}, 32'(done), 32'd0);
        chk({tag, " wr_en_idle"}, 32'(out_wr_en), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < IMAGE_SIZE; i++) mem[i] = W'(i % 256);
        reset    = 1'b1;
        start    = 1'b0;
        out_full = 1'b0;
        repeat (3) @(posedge clock);
        #5;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst wr_en", 32'(out_wr_en), 32'd0);
        chk("rst out_din", 32'(out_din), 32'd0);
        chk("rst rd_addr", 32'(bram_rd_addr), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_check("pre");

        run_frame(0, 16, 3, 19);
        idle_check("plain");

        run_frame(1, 16, 3, 27);
        idle_check("stall");

        run_frame(2, 16, 4, 35);
        idle_check("toggle");

        run_frame(3, 16, 3, 19);
        idle_check("restart");

        run_frame(4, 6, 3, -1);
        run_frame(0, 16, 3, 19);
        idle_check("after_reset");

        run_frame(0, 16, 3, 19);
        run_frame(0, 16, 3, 19);
        idle_check("b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
